// File: rtl/exe_stage.sv
// Execute stage: latches the decode bus, computes ALU/multiply results, runs a
// 32-iteration restoring divider and hands results to the memory stage.
module exe_stage #(
    parameter int unsigned ID_TO_EXE_LEN  = 163,
    parameter int unsigned EXE_TO_MEM_LEN = 75,
    parameter int unsigned EXE_RF_LEN     = 38
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [ID_TO_EXE_LEN-1:0]  ID_to_EXE_BUS,
    input  logic                      ID_to_EXE_valid,
    output logic                      EXE_allowin,
    input  logic                      MEM_allowin,
    output logic                      EXE_to_MEM_valid,
    output logic [EXE_TO_MEM_LEN-1:0] EXE_to_MEM_BUS,
    output logic [EXE_RF_LEN-1:0]     EXE_RF_BUS,
    output logic                      data_sram_en,
    output logic [3:0]                data_sram_we,
    output logic [31:0]               data_sram_addr,
    output logic [31:0]               data_sram_wdata
);

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    logic                     EXE_valid;
    logic                     EXE_ready_go;
    logic [ID_TO_EXE_LEN-1:0] payload;

    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rkd_value;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  load_op;
    logic        rfrom_mem;
    logic [6:0]  mul_div_op;

    assign {pc, gr_we, dest, rkd_value, mem_en, mem_we, alu_op,
            src1, src2, load_op, rfrom_mem, mul_div_op} = payload;

    // Pipeline valid and payload registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            EXE_valid <= 1'b0;
            payload   <= '0;
        end else begin
            if (EXE_allowin)
                EXE_valid <= ID_to_EXE_valid;
            if (ID_to_EXE_valid && EXE_allowin)
                payload <= ID_to_EXE_BUS;
        end
    end

    // ALU: one-hot select, no bit set yields zero
    logic [31:0] alu_result;
    always_comb begin
        alu_result = ({32{alu_op[0]}}  & (src1 + src2))
                   | ({32{alu_op[1]}}  & (src1 - src2))
                   | ({32{alu_op[2]}}  & {31'd0, $signed(src1) < $signed(src2)})
                   | ({32{alu_op[3]}}  & {31'd0, src1 < src2})
                   | ({32{alu_op[4]}}  & (src1 & src2))
                   | ({32{alu_op[5]}}  & ~(src1 | src2))
                   | ({32{alu_op[6]}}  & (src1 | src2))
                   | ({32{alu_op[7]}}  & (src1 ^ src2))
                   | ({32{alu_op[8]}}  & (src1 << src2[4:0]))
                   | ({32{alu_op[9]}}  & (src1 >> src2[4:0]))
                   | ({32{alu_op[10]}} & 32'($signed(src1) >>> src2[4:0]))
                   | ({32{alu_op[11]}} & src2);
    end

    // Signed high word derived from the unsigned product by subtracting the
    // cross terms contributed by negative operands.
    logic [63:0] prod_u;
    logic [31:0] mulh_s;
    assign prod_u = {32'd0, src1} * {32'd0, src2};
    assign mulh_s = prod_u[63:32] - (src1[31] ? src2 : 32'd0) - (src2[31] ? src1 : 32'd0);

    logic is_div;
    logic div_signed;
    assign is_div     = |mul_div_op[3:0];
    assign div_signed = mul_div_op[3] | mul_div_op[2];

    div_state_t  div_state;
    logic [4:0]  div_cnt;
    logic [31:0] div_rem;
    logic [31:0] div_quo;
    logic [31:0] div_divisor;
    logic        div_neg_q;
    logic        div_neg_r;

    logic [32:0] div_shifted;
    logic [32:0] div_diff;
    assign div_shifted = {div_rem, div_quo[31]};
    assign div_diff    = div_shifted - {1'b0, div_divisor};

    // Divider FSM: operand magnitudes latched on entry, one quotient bit per BUSY cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_state   <= DIV_IDLE;
            div_cnt     <= 5'd0;
            div_rem     <= 32'd0;
            div_quo     <= 32'd0;
            div_divisor <= 32'd0;
            div_neg_q   <= 1'b0;
            div_neg_r   <= 1'b0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (EXE_valid && is_div) begin
                        div_quo     <= (div_signed && src1[31]) ? -src1 : src1;
                        div_divisor <= (div_signed && src2[31]) ? -src2 : src2;
                        div_rem     <= 32'd0;
                        div_neg_q   <= div_signed & (src1[31] ^ src2[31]);
                        div_neg_r   <= div_signed & src1[31];
                        div_cnt     <= 5'd0;
                        div_state   <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    div_rem   <= div_diff[32] ? div_shifted[31:0] : div_diff[31:0];
                    div_quo   <= {div_quo[30:0], ~div_diff[32]};
                    div_cnt   <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31)
                        div_state <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (EXE_ready_go && MEM_allowin)
                        div_state <= DIV_IDLE;
                end
                default: div_state <= DIV_IDLE;
            endcase
        end
    end

    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;
    assign div_by_zero = (div_divisor == 32'd0);
    assign quotient    = div_by_zero ? 32'hFFFF_FFFF : (div_neg_q ? -div_quo : div_quo);
    assign remainder   = div_by_zero ? src1 : (div_neg_r ? -div_rem : div_rem);

    logic [31:0] result;
    always_comb begin
        result = alu_result;
        if (|mul_div_op)
            result = ({32{mul_div_op[6]}} & prod_u[31:0])
                   | ({32{mul_div_op[5]}} & mulh_s)
                   | ({32{mul_div_op[4]}} & prod_u[63:32])
                   | ({32{mul_div_op[3] | mul_div_op[1]}} & quotient)
                   | ({32{mul_div_op[2] | mul_div_op[0]}} & remainder);
    end

    assign EXE_ready_go     = !is_div || (div_state == DIV_DONE);
    assign EXE_allowin      = !EXE_valid || (EXE_ready_go && MEM_allowin);
    assign EXE_to_MEM_valid = EXE_valid && EXE_ready_go;

    // One SRAM request per instruction, issued only in the handoff cycle
    logic sram_gate;
    assign sram_gate       = EXE_valid & EXE_ready_go & MEM_allowin & (mem_en | rfrom_mem);
    assign data_sram_en    = sram_gate;
    assign data_sram_we    = mem_we & {4{sram_gate}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

    logic not_ready;
    assign not_ready  = EXE_valid & (rfrom_mem | (is_div & (div_state != DIV_DONE)));
    assign EXE_RF_BUS = {((EXE_valid && gr_we) ? dest : 5'd0), not_ready, result};

    assign EXE_to_MEM_BUS = {pc, gr_we, dest, result, load_op, rfrom_mem};

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU/multiply results, store stall, divider
// latency and corner cases, and reset abort mid-divide.
module tb_exe_stage;

    localparam int unsigned ID_TO_EXE_LEN  = 163;
    localparam int unsigned EXE_TO_MEM_LEN = 75;
    localparam int unsigned EXE_RF_LEN     = 38;

    logic                      clk = 1'b0;
    logic                      resetn;
    logic [ID_TO_EXE_LEN-1:0]  ID_to_EXE_BUS;
    logic                      ID_to_EXE_valid;
    logic                      EXE_allowin;
    logic                      MEM_allowin;
    logic                      EXE_to_MEM_valid;
    logic [EXE_TO_MEM_LEN-1:0] EXE_to_MEM_BUS;
    logic [EXE_RF_LEN-1:0]     EXE_RF_BUS;
    logic                      data_sram_en;
    logic [3:0]                data_sram_we;
    logic [31:0]               data_sram_addr;
    logic [31:0]               data_sram_wdata;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .ID_to_EXE_BUS    (ID_to_EXE_BUS),
        .ID_to_EXE_valid  (ID_to_EXE_valid),
        .EXE_allowin      (EXE_allowin),
        .MEM_allowin      (MEM_allowin),
        .EXE_to_MEM_valid (EXE_to_MEM_valid),
        .EXE_to_MEM_BUS   (EXE_to_MEM_BUS),
        .EXE_RF_BUS       (EXE_RF_BUS),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata)
    );

    logic [31:0] mem_result;
    logic [31:0] mem_pc;
    logic [4:0]  rf_dest;
    logic        rf_nr;
    assign mem_result = EXE_to_MEM_BUS[36:5];
    assign mem_pc     = EXE_to_MEM_BUS[74:43];
    assign rf_dest    = EXE_RF_BUS[37:33];
    assign rf_nr      = EXE_RF_BUS[32];

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] PC0 = 32'h1C00_0000;

    task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [162:0] mk(input logic gr_we, input logic [4:0] dest,
                                        input logic [31:0] rkd, input logic mem_en,
                                        input logic [3:0] mem_we, input logic [11:0] alu_op,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [3:0] load_op, input logic rfrom,
                                        input logic [6:0] md);
        return {PC0, gr_we, dest, rkd, mem_en, mem_we, alu_op, s1, s2, load_op, rfrom, md};
    endfunction

    function automatic logic [162:0] alu_i(input logic [11:0] op, input logic [31:0] s1,
                                           input logic [31:0] s2);
        return mk(1'b1, 5'd4, 32'd0, 1'b0, 4'd0, op, s1, s2, 4'd0, 1'b0, 7'd0);
    endfunction

    function automatic logic [162:0] md_i(input logic [6:0] md, input logic [31:0] s1,
                                          input logic [31:0] s2);
        return mk(1'b1, 5'd9, 32'd0, 1'b0, 4'd0, 12'd0, s1, s2, 4'd0, 1'b0, md);
    endfunction

    task automatic run_single(input string tag, input logic [162:0] bus, input logic [31:0] exp);
        ID_to_EXE_BUS   = bus;
        ID_to_EXE_valid = 1'b1;
        tick();
        ID_to_EXE_valid = 1'b0;
        #1;
        chk({tag, "_valid"}, 75'(EXE_to_MEM_valid), 75'(1));
        chk(tag, 75'(mem_result), 75'(exp));
    endtask

    // Counts cycles in the stage until handoff; the entry cycle is cycle 1
    task automatic run_div(input string tag, input logic [162:0] bus, input logic [31:0] exp);
        int n;
        ID_to_EXE_BUS   = bus;
        ID_to_EXE_valid = 1'b1;
        tick();
        ID_to_EXE_valid = 1'b0;
        n = 1;
        #1;
        while (!EXE_to_MEM_valid && n < 100) begin
            if (n == 1 || n == 33) begin
                chk({tag, "_allowin"}, 75'(EXE_allowin), 75'(0));
                chk({tag, "_notready"}, 75'(rf_nr), 75'(1));
            end
            tick();
            n++;
            #1;
        end
        chk({tag, "_latency"}, 75'(n), 75'(34));
        chk(tag, 75'(mem_result), 75'(exp));
    endtask

    initial begin
        resetn          = 1'b0;
        ID_to_EXE_BUS   = '0;
        ID_to_EXE_valid = 1'b0;
        MEM_allowin     = 1'b1;
        tick();
        tick();
        chk("rst_valid",    75'(EXE_to_MEM_valid), 75'(0));
        chk("rst_allowin",  75'(EXE_allowin),      75'(1));
        chk("rst_sram_en",  75'(data_sram_en),     75'(0));
        chk("rst_sram_we",  75'(data_sram_we),     75'(0));
        chk("rst_rf_dest",  75'(rf_dest),          75'(0));
        chk("rst_rf_nr",    75'(rf_nr),            75'(0));
        resetn = 1'b1;
        tick();

        // add overflow boundary, single-cycle handoff
        run_single("add", alu_i(12'h001, 32'h7FFF_FFFF, 32'h1), 32'h8000_0000);
        chk("add_allowin", 75'(EXE_allowin), 75'(1));
        chk("add_pc",      75'(mem_pc),      75'(PC0));
        chk("add_rf_dest", 75'(rf_dest),     75'(4));
        tick();
        chk("add_pulse",   75'(EXE_to_MEM_valid), 75'(0));

        run_single("sub",   alu_i(12'h002, 32'd5, 32'd7),               32'hFFFF_FFFE);
        run_single("slt",   alu_i(12'h004, 32'hFFFF_FFFF, 32'd1),       32'd1);
        run_single("sltu",  alu_i(12'h008, 32'hFFFF_FFFF, 32'd1),       32'd0);
        run_single("and",   alu_i(12'h010, 32'h0000_F0F0, 32'h0000_FF00), 32'h0000_F000);
        run_single("nor",   alu_i(12'h020, 32'd0, 32'd0),               32'hFFFF_FFFF);
        run_single("or",    alu_i(12'h040, 32'h0000_00F0, 32'h0000_000F), 32'h0000_00FF);
        run_single("xor",   alu_i(12'h080, 32'h0000_00FF, 32'h0000_000F), 32'h0000_00F0);
        run_single("sll",   alu_i(12'h100, 32'd1, 32'h0000_003F),       32'h8000_0000);
        run_single("srl",   alu_i(12'h200, 32'h8000_0000, 32'd4),       32'h0800_0000);
        run_single("sra",   alu_i(12'h400, 32'h8000_0000, 32'd4),       32'hF800_0000);
        run_single("lu12i", alu_i(12'h800, 32'h1111_1111, 32'hABCD_E000), 32'hABCD_E000);
        run_single("noop",  alu_i(12'h000, 32'h1111_1111, 32'h2222_2222), 32'd0);

        run_single("mulh_w",  md_i(7'b0100000, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
        run_single("mulh_wu", md_i(7'b0010000, 32'hFFFF_FFFF, 32'd2), 32'h0000_0001);
        run_single("mul_w",   md_i(7'b1000000, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFE);
        tick();

        // store held off by the memory stage for three cycles
        MEM_allowin     = 1'b0;
        ID_to_EXE_BUS   = mk(1'b0, 5'd0, 32'hDEAD_BEEF, 1'b1, 4'hF, 12'h001,
                             32'h0000_1000, 32'h8, 4'd0, 1'b0, 7'd0);
        ID_to_EXE_valid = 1'b1;
        tick();
        ID_to_EXE_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_stall_en",      75'(data_sram_en), 75'(0));
            chk("st_stall_allowin", 75'(EXE_allowin),  75'(0));
            tick();
        end
        MEM_allowin = 1'b1;
        #1;
        chk("st_en",    75'(data_sram_en),    75'(1));
        chk("st_we",    75'(data_sram_we),    75'(4'hF));
        chk("st_addr",  75'(data_sram_addr),  75'(32'h0000_1008));
        chk("st_wdata", 75'(data_sram_wdata), 75'(32'hDEAD_BEEF));
        tick();
        chk("st_once",  75'(data_sram_en),    75'(0));

        // load request and hazard flag
        ID_to_EXE_BUS   = mk(1'b1, 5'd7, 32'd0, 1'b0, 4'd0, 12'h001,
                             32'h0000_2000, 32'h4, 4'b0001, 1'b1, 7'd0);
        ID_to_EXE_valid = 1'b1;
        tick();
        ID_to_EXE_valid = 1'b0;
        #1;
        chk("ld_en",       75'(data_sram_en),   75'(1));
        chk("ld_we",       75'(data_sram_we),   75'(0));
        chk("ld_addr",     75'(data_sram_addr), 75'(32'h0000_2004));
        chk("ld_notready", 75'(rf_nr),          75'(1));
        chk("ld_rf_dest",  75'(rf_dest),        75'(7));
        tick();

        // back-to-back divides
        run_div("div_w",    md_i(7'b0001000, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        run_div("mod_w",    md_i(7'b0000100, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        run_div("div_wu_z", md_i(7'b0000010, 32'h0000_1234, 32'd0), 32'hFFFF_FFFF);
        run_div("mod_wu_z", md_i(7'b0000001, 32'h0000_1234, 32'd0), 32'h0000_1234);
        run_div("div_w_ov", md_i(7'b0001000, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        run_div("mod_w_ov", md_i(7'b0000100, 32'h8000_0000, 32'hFFFF_FFFF), 32'd0);
        run_div("mod_w_z",  md_i(7'b0000100, 32'hFFFF_FFF9, 32'd0), 32'hFFFF_FFF9);
        tick();

        // reset in the middle of a divide
        ID_to_EXE_BUS   = md_i(7'b0001000, 32'd1000, 32'd3);
        ID_to_EXE_valid = 1'b1;
        tick();
        ID_to_EXE_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid",   75'(EXE_to_MEM_valid), 75'(0));
        chk("mid_rst_allowin", 75'(EXE_allowin),      75'(1));
        chk("mid_rst_nr",      75'(rf_nr),            75'(0));
        chk("mid_rst_dest",    75'(rf_dest),          75'(0));
        chk("mid_rst_en",      75'(data_sram_en),     75'(0));
        tick();
        resetn = 1'b1;
        tick();
        run_single("post_rst_add", alu_i(12'h001, 32'd40, 32'd2), 32'd42);
        chk("post_rst_nr", 75'(rf_nr), 75'(0));
        tick();
        run_div("post_rst_div", md_i(7'b0000010, 32'd100, 32'd7), 32'd14);
        run_div("post_rst_mod", md_i(7'b0000001, 32'd100, 32'd7), 32'd2);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
